// File: rtl/spi_input_sync.sv
// Multi-stage synchronizer for one asynchronous input bit.
// The reset value is set per instance so that idle-high lines can start deasserted.
module spi_input_sync #(
  parameter int   STAGES  = 2,
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] sync_r;

  // Shift the raw input through the flop chain; the last stage is the usable sample.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync_r <= {STAGES{RST_VAL}};
    end else begin
      sync_r[0] <= d;
      for (int i = 1; i < STAGES; i++) begin
        sync_r[i] <= sync_r[i-1];
      end
    end
  end

  assign q = sync_r[STAGES-1];

endmodule

// File: rtl/spi_slave_link.sv
// SPI mode-0 slave front end: MSB first, active-low cs, oversampled by clk.
// Receives words into data_out (ready pulse) and transmits data_in (load pulse),
// with back-to-back words inside one cs frame and partial-word error reporting.
module spi_slave_link #(
  parameter int DATA_WIDTH  = 32,
  parameter int SYNC_STAGES = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] data_in,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  ready,
  output logic                  load,
  output logic                  frame_err,
  input  logic                  sclk,
  input  logic                  mosi,
  input  logic                  cs,
  output logic                  miso
);

  localparam logic ST_IDLE  = 1'b0;
  localparam logic ST_SHIFT = 1'b1;

  localparam int                CNT_W    = $clog2(DATA_WIDTH) + 1;
  localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_WIDTH - 1);

  logic                    sclk_s, cs_s, mosi_s;
  logic                    sclk_d_r, cs_d_r;
  logic                    sclk_rise_s, sclk_fall_s, cs_fall_s, cs_rise_s;
  logic                    state_r;
  logic                    word_done_r;
  logic [CNT_W-1:0]        bit_cnt_r;
  logic [DATA_WIDTH-2:0]   rx_shift_r;
  logic [DATA_WIDTH-2:0]   tx_shift_r;
  logic [DATA_WIDTH-1:0]   rx_next_s;
  logic [DATA_WIDTH-1:0]   tx_next_s;
  logic [SYNC_STAGES:0]    settle_r;

  spi_input_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_sclk (
    .clk(clk), .rst(rst), .d(sclk), .q(sclk_s)
  );
  spi_input_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_cs (
    .clk(clk), .rst(rst), .d(cs), .q(cs_s)
  );
  spi_input_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_mosi (
    .clk(clk), .rst(rst), .d(mosi), .q(mosi_s)
  );

  // Delay the synchronized sclk/cs by one clk for edge detection; also track
  // when the synchronizer chain holds only post-reset samples, so a cs held
  // low through reset release is not mistaken for a new frame start.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sclk_d_r <= 1'b0;
      cs_d_r   <= 1'b1;
      settle_r <= {(SYNC_STAGES+1){1'b0}};
    end else begin
      sclk_d_r <= sclk_s;
      cs_d_r   <= cs_s;
      settle_r <= {settle_r[SYNC_STAGES-1:0], 1'b1};
    end
  end

  assign sclk_rise_s = sclk_s & ~sclk_d_r;
  assign sclk_fall_s = ~sclk_s & sclk_d_r;
  assign cs_fall_s   = ~cs_s & cs_d_r & settle_r[SYNC_STAGES];
  assign cs_rise_s   = cs_s & ~cs_d_r;

  // mosi is taken from the same synchronized sample as the sclk edge.
  assign rx_next_s = {rx_shift_r, mosi_s};
  assign tx_next_s = {tx_shift_r, 1'b0};

  // Link FSM: frame tracking, receive/transmit shifting and the one-clk pulses.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r     <= ST_IDLE;
      data_out    <= {DATA_WIDTH{1'b0}};
      ready       <= 1'b0;
      load        <= 1'b0;
      frame_err   <= 1'b0;
      miso        <= 1'b0;
      rx_shift_r  <= {(DATA_WIDTH-1){1'b0}};
      tx_shift_r  <= {(DATA_WIDTH-1){1'b0}};
      bit_cnt_r   <= CNT_ZERO;
      word_done_r <= 1'b0;
    end else begin
      ready     <= 1'b0;
      load      <= 1'b0;
      frame_err <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          miso <= 1'b0;
          if (cs_fall_s) begin
            state_r     <= ST_SHIFT;
            tx_shift_r  <= data_in[DATA_WIDTH-2:0];
            miso        <= data_in[DATA_WIDTH-1];
            load        <= 1'b1;
            bit_cnt_r   <= CNT_ZERO;
            rx_shift_r  <= {(DATA_WIDTH-1){1'b0}};
            word_done_r <= 1'b0;
          end else begin
            state_r <= ST_IDLE;
          end
        end
        ST_SHIFT: begin
          if (cs_rise_s) begin
            // End of frame wins over any sclk edge seen in the same clk.
            state_r     <= ST_IDLE;
            miso        <= 1'b0;
            frame_err   <= (bit_cnt_r != CNT_ZERO);
            bit_cnt_r   <= CNT_ZERO;
            word_done_r <= 1'b0;
          end else if (sclk_rise_s) begin
            rx_shift_r <= rx_next_s[DATA_WIDTH-2:0];
            if (bit_cnt_r == LAST_BIT) begin
              data_out    <= rx_next_s;
              ready       <= 1'b1;
              bit_cnt_r   <= CNT_ZERO;
              word_done_r <= 1'b1;
            end else begin
              bit_cnt_r <= bit_cnt_r + CNT_ONE;
            end
          end else if (sclk_fall_s) begin
            if (word_done_r) begin
              // Next word of a multi-word frame: reload instead of shifting.
              tx_shift_r  <= data_in[DATA_WIDTH-2:0];
              miso        <= data_in[DATA_WIDTH-1];
              load        <= 1'b1;
              word_done_r <= 1'b0;
            end else begin
              tx_shift_r <= tx_next_s[DATA_WIDTH-2:0];
              miso       <= tx_next_s[DATA_WIDTH-1];
            end
          end else begin
            state_r <= ST_SHIFT;
          end
        end
        default: begin
          state_r <= ST_IDLE;
          miso    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_spi_slave_link.sv
// Self-checking bench for spi_slave_link: a behavioural SPI master drives
// frames; expected words come from what the master sent and what data_in held.
module tb_spi_slave_link;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] data_in;
  logic [31:0] data_out;
  logic        ready, load, frame_err;
  logic        sclk, mosi, cs, miso;

  int total = 0;
  int bad   = 0;
  int ready_cnt = 0, load_cnt = 0, ferr_cnt = 0;
  logic [31:0] rx_q[$];

  spi_slave_link #(.DATA_WIDTH(32), .SYNC_STAGES(2)) dut (
    .clk(clk), .rst(rst), .data_in(data_in), .data_out(data_out),
    .ready(ready), .load(load), .frame_err(frame_err),
    .sclk(sclk), .mosi(mosi), .cs(cs), .miso(miso)
  );

  always #5 clk = ~clk;

  // Pulse monitor: counts one-clk pulses and records every delivered word.
  always @(negedge clk) begin
    if (ready === 1'b1) begin
      ready_cnt = ready_cnt + 1;
      rx_q.push_back(data_out);
    end
    if (load === 1'b1) load_cnt = load_cnt + 1;
    if (frame_err === 1'b1) ferr_cnt = ferr_cnt + 1;
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total = total + 1;
    if (act !== exp) begin
      bad = bad + 1;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic wait_clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Mode-0 master: mosi set while sclk low, miso sampled at sclk rise. The final
  // sclk fall coincides with cs rise so it never counts as a word-boundary fall.
  task automatic run_frame(input logic [31:0] mw[4], input logic [31:0] din[4],
                           input int nw, input int nlast, input int hp,
                           output logic [31:0] got[4]);
    int nb;
    for (int w = 0; w < 4; w++) got[w] = 32'h0;
    @(negedge clk);
    data_in = din[0];
    cs = 1'b0;
    wait_clks(hp);
    for (int w = 0; w < nw; w++) begin
      nb = (w == nw - 1) ? nlast : 32;
      for (int b = 0; b < nb; b++) begin
        mosi = mw[w][31-b];
        wait_clks(hp);
        sclk = 1'b1;
        got[w][31-b] = miso;
        wait_clks(hp);
        if (w == nw - 1 && b == nb - 1) cs = 1'b1;
        sclk = 1'b0;
        if (b == 1 && w + 1 < nw) data_in = din[w+1];
      end
    end
    if (nlast == 0) cs = 1'b1;
    mosi = 1'b0;
    wait_clks(12);
  endtask

  typedef struct {
    logic [31:0] mw;
    logic [31:0] din;
    int          hp;
    int          nbits;
    int          exp_ready;
    int          exp_ferr;
    int          exp_load;
    logic [31:0] exp_dout;
  } vec_t;

  vec_t        vecs[6];
  logic [31:0] mw[4], din[4], got[4];
  int          r0, l0, f0;
  int          hps[2];
  logic        miso_high;

  initial begin
    vecs[0] = '{32'hA1A2A3A4, 32'h5A5A5A5A, 4, 32, 1, 0, 1, 32'hA1A2A3A4};
    vecs[1] = '{32'hD1D2D3D4, 32'h00000000, 4, 13, 0, 1, 1, 32'hA1A2A3A4};
    vecs[2] = '{32'h0F0F0F0F, 32'h87654321, 6, 32, 1, 0, 1, 32'h0F0F0F0F};
    vecs[3] = '{32'h13572468, 32'hFFFF0000, 4,  0, 0, 0, 1, 32'h0F0F0F0F};
    vecs[4] = '{32'hFFFFFFFF, 32'h00000000, 50, 32, 1, 0, 1, 32'hFFFFFFFF};
    vecs[5] = '{32'h12345678, 32'h9ABCDEF0, 4, 31, 0, 1, 1, 32'hFFFFFFFF};
    hps[0] = 4;
    hps[1] = 50;

    rst = 1'b0; cs = 1'b1; sclk = 1'b0; mosi = 1'b0; data_in = 32'h0;
    wait_clks(3);
    check("reset_outputs", {data_out, ready, load, frame_err, miso}, 64'h0);
    rst = 1'b1;
    wait_clks(5);

    // Directed single-word frames, including partial and empty frames.
    for (int i = 0; i < 6; i++) begin
      r0 = ready_cnt; l0 = load_cnt; f0 = ferr_cnt;
      mw[0] = vecs[i].mw; din[0] = vecs[i].din;
      run_frame(mw, din, 1, vecs[i].nbits, vecs[i].hp, got);
      check($sformatf("v%0d_ready", i), 64'(ready_cnt - r0), 64'(vecs[i].exp_ready));
      check($sformatf("v%0d_ferr", i), 64'(ferr_cnt - f0), 64'(vecs[i].exp_ferr));
      check($sformatf("v%0d_load", i), 64'(load_cnt - l0), 64'(vecs[i].exp_load));
      check($sformatf("v%0d_dout", i), 64'(data_out), 64'(vecs[i].exp_dout));
      if (vecs[i].nbits == 32) check($sformatf("v%0d_miso", i), 64'(got[0]), 64'(vecs[i].din));
    end

    // Two words in one frame, data_in changed after the first load.
    rx_q.delete();
    r0 = ready_cnt; l0 = load_cnt;
    mw[0] = 32'hB1B2B3B4; mw[1] = 32'hC1C2C3C4;
    din[0] = 32'hCAFEF00D; din[1] = 32'h12345678;
    run_frame(mw, din, 2, 32, 4, got);
    check("mw_ready", 64'(ready_cnt - r0), 64'd2);
    check("mw_load", 64'(load_cnt - l0), 64'd2);
    check("mw_word0", 64'((rx_q.size() > 0) ? rx_q[0] : 32'hX), 64'h00000000B1B2B3B4);
    check("mw_word1", 64'((rx_q.size() > 1) ? rx_q[1] : 32'hX), 64'h00000000C1C2C3C4);
    check("mw_miso0", 64'(got[0]), 64'h00000000CAFEF00D);
    check("mw_miso1", 64'(got[1]), 64'h0000000012345678);

    // Reset in the middle of a frame, with cs still low at release.
    r0 = ready_cnt; l0 = load_cnt; f0 = ferr_cnt;
    @(negedge clk);
    data_in = 32'h600DF00D; cs = 1'b0;
    wait_clks(4);
    for (int b = 0; b < 20; b++) begin
      mosi = 1'(b % 3);
      wait_clks(4); sclk = 1'b1;
      wait_clks(4); sclk = 1'b0;
    end
    wait_clks(2);
    rst = 1'b0;
    wait_clks(3);
    check("rst_mid_outputs", {data_out, ready, load, frame_err, miso}, 64'h0);
    wait_clks(2);
    rst = 1'b1;
    wait_clks(15);
    check("rst_no_ready", 64'(ready_cnt - r0), 64'd0);
    check("rst_no_ferr", 64'(ferr_cnt - f0), 64'd0);
    check("rst_no_restart", 64'(load_cnt - l0), 64'd1);
    check("rst_miso_idle", 64'(miso), 64'd0);
    cs = 1'b1;
    wait_clks(10);
    r0 = ready_cnt;
    mw[0] = 32'hA1A2A3A4; din[0] = 32'h0BADCAFE;
    run_frame(mw, din, 1, 32, 4, got);
    check("post_rst_ready", 64'(ready_cnt - r0), 64'd1);
    check("post_rst_dout", 64'(data_out), 64'h00000000A1A2A3A4);
    check("post_rst_miso", 64'(got[0]), 64'h000000000BADCAFE);

    // sclk toggling while cs is deasserted must be invisible.
    r0 = ready_cnt; l0 = load_cnt; f0 = ferr_cnt;
    miso_high = 1'b0;
    for (int t = 0; t < 20; t++) begin
      sclk = ~sclk; mosi = ~mosi;
      for (int k = 0; k < 4; k++) begin
        @(negedge clk);
        if (miso !== 1'b0) miso_high = 1'b1;
      end
    end
    sclk = 1'b0; mosi = 1'b0;
    wait_clks(6);
    check("idle_pulses", 64'((ready_cnt - r0) + (load_cnt - l0) + (ferr_cnt - f0)), 64'd0);
    check("idle_miso", 64'(miso_high), 64'd0);

    // Random two-word frames at the fastest and a slow sclk rate.
    for (int h = 0; h < 2; h++) begin
      for (int f = 0; f < ((h == 0) ? 6 : 3); f++) begin
        rx_q.delete();
        r0 = ready_cnt;
        for (int w = 0; w < 2; w++) begin
          mw[w] = $urandom;
          din[w] = $urandom;
        end
        run_frame(mw, din, 2, 32, hps[h], got);
        check($sformatf("rnd_hp%0d_f%0d_ready", hps[h], f), 64'(ready_cnt - r0), 64'd2);
        for (int w = 0; w < 2; w++) begin
          check($sformatf("rnd_hp%0d_f%0d_rx%0d", hps[h], f, w),
                64'((rx_q.size() > w) ? rx_q[w] : 32'hX), 64'(mw[w]));
          check($sformatf("rnd_hp%0d_f%0d_tx%0d", hps[h], f, w), 64'(got[w]), 64'(din[w]));
        end
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/spi_slave_link.md
SPI_SLAVE_LINK -- requirements
Module: spi_slave_link

Interface
REQ-001 Parameter DATA_WIDTH, default 32, SHALL set the SPI word length in bits and the width of data_in/data_out.
REQ-002 Parameter SYNC_STAGES, default 2, SHALL set the synchronizer depth for sclk, cs and mosi.
REQ-003 clk  input  1  system clock; all state changes on rising edge.
REQ-004 rst  input  1  asynchronous, active-low reset.
REQ-005 data_in  input  DATA_WIDTH  word to transmit on miso; sampled at each word load.
REQ-006 data_out  output  DATA_WIDTH  last completely received word; held until the next completed word.
REQ-007 ready  output  1  one-clk pulse when data_out is updated.
REQ-008 load  output  1  one-clk pulse when data_in has been captured into the transmit shifter.
REQ-009 frame_err  output  1  one-clk pulse when cs deasserts with a partial word.
REQ-010 sclk, mosi, cs  input  1 each  SPI mode 0, MSB first, cs active-low, asynchronous to clk.
REQ-011 miso  output  1  serial transmit data; driven 0 while cs is deasserted.

Function
REQ-012 sclk, cs and mosi SHALL each pass through SYNC_STAGES flip-flops; edges SHALL be detected from the last stage and one additional delay register.
REQ-013 FSM states: IDLE, SHIFT. IDLE -> SHIFT on synchronized cs falling edge. SHIFT -> IDLE on synchronized cs rising edge.
REQ-014 IDLE -> SHIFT SHALL capture data_in into tx_shift, pulse load, clear bit_cnt and the receive shifter, and drive miso with data_in[DATA_WIDTH-1] on the next clk.
REQ-015 In SHIFT, each synchronized sclk rising edge SHALL shift the mosi value, aligned to that same synchronized sample, into the LSB of rx_shift and increment bit_cnt.
REQ-016 In SHIFT, each synchronized sclk falling edge SHALL shift tx_shift left by one and present the new MSB on miso.
REQ-017 On the rising edge that completes bit DATA_WIDTH-1, data_out SHALL take the full word on the following clk, and ready SHALL pulse in that same cycle.
REQ-018 Word-completion latency SHALL be exactly 1 clk after the sclk edge is detected.
REQ-019 After a completed word with cs still asserted, bit_cnt SHALL wrap to 0.
REQ-020 After a completed word with cs still asserted, the next sclk falling edge SHALL reload tx_shift from data_in instead of shifting, and SHALL pulse load, so multi-word frames are supported.
REQ-021 A cs rising edge with 0 < bit_cnt < DATA_WIDTH SHALL discard the partial word, pulse frame_err, leave data_out unchanged, and not pulse ready.
REQ-022 A cs rising edge with bit_cnt == 0 SHALL return to IDLE without any pulse.
REQ-023 An sclk edge detected in the same clk as a cs rising edge SHALL be ignored.
REQ-024 sclk edges in IDLE SHALL be ignored.
REQ-025 Correct operation SHALL be guaranteed for sclk half-period >= SYNC_STAGES+2 clk periods.
REQ-026 bit_cnt width SHALL be clog2(DATA_WIDTH)+1 bits; no arithmetic other than increment and compare.

Reset
REQ-027 With rst low: state=IDLE; data_out=0; ready=0; load=0; frame_err=0; miso=0; shifters, bit_cnt and synchronizers=0, with the cs synchronizer set to 1 (deasserted).
REQ-028 Reset asserted mid-frame SHALL abort the frame without ready or frame_err.
REQ-029 After rst release, a frame SHALL start only on a fresh cs falling edge.

Structure
REQ-030 No shared package; DATA_WIDTH and SYNC_STAGES SHALL be module parameters, and state encodings SHALL be localparams.
REQ-031 The synchronizer SHALL be one reusable sub-module, spi_input_sync (parameter STAGES; async active-low reset; per-instance reset value), instantiated three times.
REQ-032 The block SHALL replace the serial front end inside pu_slave_spi and feed its receive buffer from data_out/ready; its transmit buffer SHALL be drained via data_in/load.

Verification
REQ-033 Master sends 32'hA1A2A3A4 while data_in=32'h5A5A5A5A -> ready pulses once, data_out=32'hA1A2A3A4, and the master receives 32'h5A5A5A5A.
REQ-034 One cs frame of two words, B1B2B3B4 then C1C2C3C4, with data_in changed to 32'h12345678 after the first load -> two ready pulses, data_out sequence B1B2B3B4, C1C2C3C4; second miso word 32'h12345678; two load pulses.
REQ-035 cs deasserted after 13 bits of 32'hD1D2D3D4 -> frame_err pulses, no ready, data_out keeps its previous value, and the next full frame is received correctly.
REQ-036 rst driven low at bit 20 of a frame, then released -> all outputs 0, and a following frame of 32'hA1A2A3A4 is received correctly.
REQ-037 sclk toggling with cs high -> no ready, load or frame_err pulses, and miso stays 0.
REQ-038 Sweep the sclk half-period at the minimum of 4 clk and at 50 clk with random words -> all words bit-exact in both directions.
